// File: rtl/cpu_core_p.sv
// ---------------------------------------------------------------------------
// cpu_core_p -- parametrised fetch/execute core with a request/ready memory
// handshake and wait-state stalling.
//
// Sequencing: IDLE -> FETCH -> EXEC -> (MEM) -> FETCH ..., plus a terminal
// HALT state that only reset leaves. Every memory-side output is decoded
// from registered state (state, pc, instruction register, register file).
// There is no combinational path from mem_ready or mem_rdata to any output.
//
// Parameters:
//   DATA_W   register / data-bus width (32 or 64)
//   ADDR_W   pc / address width (8..DATA_W)
//   NREGS    implemented general registers (2..8); other indices read 0
//            and writes to them are dropped
//   RESET_PC pc value loaded while reset is asserted
//
// Ports:
//   clock      in   1       single clock, rising edge
//   reset      in   1       asynchronous, active-low
//   mem_addr   out  ADDR_W  fetch address (pc) or load/store address (rb)
//   mem_wdata  out  DATA_W  store data (ra) while in MEM, else 0
//   mem_rdata  in   DATA_W  fetch/load data; instructions in bits [31:0]
//   mem_req    out  1       transaction request (FETCH or MEM state)
//   mem_we     out  1       1 = write (STORE), 0 = read
//   mem_ready  in   1       completes a transaction when mem_req is high
//   halted     out  1       core is in HALT
//
// Optional feature: define CPU_CARRY_EN to add a carry flag (set by ADD,
// borrow from SUB), the ADC opcode (11) and the JC opcode (12). Without the
// macro, opcodes 11 and 12 decode as NOPs.
// ---------------------------------------------------------------------------
module cpu_core_p #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                NREGS    = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [5:0] OP_ADD   = 6'd1;
   localparam logic [5:0] OP_SUB   = 6'd2;
   localparam logic [5:0] OP_AND   = 6'd3;
   localparam logic [5:0] OP_OR    = 6'd4;
   localparam logic [5:0] OP_XOR   = 6'd5;
   localparam logic [5:0] OP_LDI   = 6'd6;
   localparam logic [5:0] OP_STORE = 6'd7;
   localparam logic [5:0] OP_LOAD  = 6'd8;
   localparam logic [5:0] OP_JZ    = 6'd9;
   localparam logic [5:0] OP_JMP   = 6'd10;
`ifdef CPU_CARRY_EN
   localparam logic [5:0] OP_ADC   = 6'd11;
   localparam logic [5:0] OP_JC    = 6'd12;
`endif
   localparam logic [5:0] OP_HALT  = 6'd63;

   // ------------------------------------------------------------------
   // Architectural state
   // ------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;

   // Instruction fields
   logic [5:0]  opcode;
   logic [2:0]  ra_idx;
   logic [2:0]  rb_idx;
   logic [2:0]  rd_idx;
   logic        hl;
   logic [15:0] imm;

   assign opcode = ir_q[5:0];
   assign ra_idx = ir_q[8:6];
   assign rb_idx = ir_q[11:9];
   assign rd_idx = ir_q[14:12];
   assign hl     = ir_q[15];
   assign imm    = ir_q[31:16];

   // ------------------------------------------------------------------
   // Register file. The read view always has 8 entries so a 3-bit index
   // is always in range; entries at or above NREGS have no storage and
   // read as zero, which also makes writes to them vanish.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] rf [8];
   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_reg
         if (gi < NREGS) begin : g_impl
            logic [DATA_W-1:0] r_q, r_d;

            always_comb begin
               r_d = r_q;
               if (rf_we && (rd_idx == 3'(gi))) begin
                  r_d = rf_wdata;
               end
            end

            always_ff @(posedge clock or negedge reset) begin
               if (!reset) begin
                  r_q <= '0;
               end else begin
                  r_q <= r_d;
               end
            end

            assign rf[gi] = r_q;
         end else begin : g_absent
            assign rf[gi] = '0;
         end
      end
   endgenerate

   // Operands come from the registered file, so an instruction that writes
   // one of its own sources still sees the pre-write value.
   logic [DATA_W-1:0] ra_val;
   logic [DATA_W-1:0] rb_val;
   logic [DATA_W-1:0] rd_val;

   assign ra_val = rf[ra_idx];
   assign rb_val = rf[rb_idx];
   assign rd_val = rf[rd_idx];

   // ------------------------------------------------------------------
   // Adders. With the carry feature the extra top bit is the carry-out
   // (ADD/ADC) or the borrow (SUB, set when ra < rb unsigned).
   // ------------------------------------------------------------------
`ifdef CPU_CARRY_EN
   logic              carry_q, carry_d;
   logic [DATA_W:0]   add_full;
   logic [DATA_W:0]   sub_full;
   logic [DATA_W:0]   adc_full;

   assign add_full = {1'b0, ra_val} + {1'b0, rb_val};
   assign sub_full = {1'b0, ra_val} - {1'b0, rb_val};
   assign adc_full = add_full + {{DATA_W{1'b0}}, carry_q};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         carry_q <= 1'b0;
      end else begin
         carry_q <= carry_d;
      end
   end
`else
   logic [DATA_W-1:0] add_res;
   logic [DATA_W-1:0] sub_res;

   assign add_res = ra_val + rb_val;
   assign sub_res = ra_val - rb_val;
`endif

   // ------------------------------------------------------------------
   // Next-state / write-back logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      rf_we    = 1'b0;
      rf_wdata = '0;
`ifdef CPU_CARRY_EN
      carry_d  = carry_q;
`endif

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata[31:0];
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode)
               OP_ADD: begin
                  rf_we = 1'b1;
`ifdef CPU_CARRY_EN
                  rf_wdata = add_full[DATA_W-1:0];
                  carry_d  = add_full[DATA_W];
`else
                  rf_wdata = add_res;
`endif
               end
               OP_SUB: begin
                  rf_we = 1'b1;
`ifdef CPU_CARRY_EN
                  rf_wdata = sub_full[DATA_W-1:0];
                  carry_d  = sub_full[DATA_W];
`else
                  rf_wdata = sub_res;
`endif
               end
               OP_AND: begin
                  rf_we    = 1'b1;
                  rf_wdata = ra_val & rb_val;
               end
               OP_OR: begin
                  rf_we    = 1'b1;
                  rf_wdata = ra_val | rb_val;
               end
               OP_XOR: begin
                  rf_we    = 1'b1;
                  rf_wdata = ra_val ^ rb_val;
               end
               OP_LDI: begin
                  rf_we = 1'b1;
                  if (hl) begin
                     // Upper-half load: only bits [31:16] change.
                     rf_wdata        = rd_val;
                     rf_wdata[31:16] = imm;
                  end else begin
                     rf_wdata = DATA_W'(imm);
                  end
               end
               OP_STORE, OP_LOAD: begin
                  state_d = S_MEM;
               end
               OP_JZ: begin
                  // pc already holds the incremented value; a taken jump
                  // simply overrides it.
                  if (ra_val == '0) begin
                     pc_d = rb_val[ADDR_W-1:0];
                  end
               end
               OP_JMP: begin
                  pc_d = ADDR_W'(imm);
               end
`ifdef CPU_CARRY_EN
               OP_ADC: begin
                  rf_we    = 1'b1;
                  rf_wdata = adc_full[DATA_W-1:0];
                  carry_d  = adc_full[DATA_W];
               end
               OP_JC: begin
                  if (carry_q) begin
                     pc_d = rb_val[ADDR_W-1:0];
                  end
               end
`endif
               OP_HALT: begin
                  state_d = S_HALT;
               end
               default: begin
                  // NOP and every unassigned opcode
               end
            endcase
         end

         S_MEM: begin
            if (mem_ready) begin
               if (opcode == OP_LOAD) begin
                  rf_we    = 1'b1;
                  rf_wdata = mem_rdata;
               end
               state_d = S_FETCH;
            end
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // ------------------------------------------------------------------
   // Memory-side outputs, decoded from registered state only. Because
   // state, pc, ir and the register file cannot change while a request is
   // pending, address/data/direction are stable for the whole request.
   // mem_req drops as soon as reset forces state to IDLE.
   // ------------------------------------------------------------------
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = '0;
      halted    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
         end
         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = (opcode == OP_STORE);
            mem_addr  = rb_val[ADDR_W-1:0];
            mem_wdata = ra_val;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/cpu_core_p.md
# cpu_core_p

Parametrised successor to the fixed 32-bit, 8-register `cpu` core. Width, register count, address width and reset vector are parameters, and the core adds a `mem_req`/`mem_ready` memory handshake with wait-state stalling. It keeps a fetch/execute state machine with a clean load/store path and a HALT state. It sits between the top level and the memory/bus fabric.

## Interface
Parameters:
- `DATA_W`, 32: register and data-bus width; legal values 32 or 64.
- `ADDR_W`, 32: PC and memory address width; legal range 8..DATA_W.
- `NREGS`, 8: number of general registers; legal range 2..8.
- `RESET_PC`, 0: PC value loaded at reset.

Ports:
- `clock`, in, 1: single clock; all state updates on posedge.
- `reset`, in, 1: asynchronous, active-low reset.
- `mem_addr`, out, ADDR_W: memory address.
- `mem_wdata`, out, DATA_W: store data.
- `mem_rdata`, in, DATA_W: fetch or load data; low 32 bits carry instructions.
- `mem_req`, out, 1: transaction request.
- `mem_we`, out, 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_ready`, in, 1: transaction completes on a posedge where `mem_req` and `mem_ready` are both high.
- `halted`, out, 1: core is in the HALT state.

## Operation
- Instruction fields (32-bit):
  - [5:0] opcode.
  - [8:6] ra.
  - [11:9] rb.
  - [14:12] rd.
  - [15] hl.
  - [31:16] imm.
- Register index rules:
  - An index ≥ NREGS reads 0.
  - A write to an index ≥ NREGS is dropped.
- Opcodes; anything not listed is a NOP:
  - 0 NOP.
  - 1 ADD rd=ra+rb.
  - 2 SUB rd=ra-rb.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 LDI:
    - hl=0: rd = zero-extended imm.
    - hl=1: rd[31:16] = imm; other bits kept.
  - 7 STORE: mem[rb] = ra.
  - 8 LOAD: rd = mem[rb].
  - 9 JZ: if ra==0 then pc = rb.
  - 10 JMP: pc = zero-extended imm.
  - 63 HALT.
- Arithmetic:
  - Results wrap modulo 2^DATA_W.
  - Addresses use rb[ADDR_W-1:0].
  - imm is truncated to ADDR_W bits if wider.
- State machine (reset value IDLE):
  - IDLE → FETCH, unconditionally.
  - FETCH:
    - `mem_req`=1, `mem_we`=0, `mem_addr`=pc.
    - Stay while `mem_ready`=0.
    - On completion: latch instruction, pc=pc+1 (wraps modulo 2^ADDR_W), → EXEC.
  - EXEC:
    - ALU ops, LDI and jumps write back this cycle, → FETCH.
    - LOAD/STORE → MEM.
    - HALT → HALT.
  - MEM:
    - `mem_req`=1, `mem_we` = (opcode==7), `mem_addr`=rb, `mem_wdata`=ra.
    - Stay until `mem_ready`.
    - On completion: LOAD writes `mem_rdata` to rd; → FETCH.
  - HALT: terminal until reset; `halted`=1.
- Jump targets replace the incremented pc.
- An instruction that reads and writes the same register reads the pre-write value.

## Timing
- Values during reset:
  - pc = RESET_PC.
  - All registers 0.
  - Instruction register 0.
  - `mem_req`=0, `mem_we`=0, `halted`=0.
  - `mem_addr`=RESET_PC.
  - `mem_wdata`=0.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from registered state only; there is no combinational path from `mem_ready` or `mem_rdata`.
- Throughput with zero-wait memory (`mem_ready` tied 1):
  - Non-memory instruction: 2 cycles.
  - LOAD/STORE: 3 cycles.
  - Each low `mem_ready` cycle adds 1 cycle.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable for as long as `mem_req` is high.
- Reset asserted mid-transaction:
  - `mem_req` drops asynchronously and the transaction is abandoned.
  - No register or PC update occurs.
  - First fetch is 2 cycles after reset deassertion (IDLE, then FETCH).
- When `mem_ready` is high and `mem_req` is low, the input is ignored.

## Configuration
- `CPU_CARRY_EN`:
  - Defined:
    - Adds a 1-bit carry flag, reset 0.
    - ADD sets it to the carry-out; SUB sets it to the borrow.
    - Opcode 11 ADC: rd = ra + rb + carry, and updates carry.
    - Opcode 12 JC: if carry then pc = rb.
  - Undefined: no flag is present, and opcodes 11 and 12 are NOPs.

## Test plan
- Reset with RESET_PC=0x10 and zero-wait memory → first `mem_req` with `mem_addr`=0x10 occurs 2 cycles after reset rises; all registers read 0.
- LDI r1=0x1234 (hl=0), then LDI r1 hl=1 imm=0xABCD, then ADD r2=r1+r1 → r1=0xABCD1234, r2=0x579A2468 (DATA_W=32).
- STORE with ra=0xDEADBEEF, rb=0x40, and `mem_ready` low for 3 cycles → `mem_req`/`mem_we`/`mem_addr`=0x40 held for 4 cycles; the write completes once; total 6 cycles.
- NREGS=4: LDI r5=7, then ADD r0=r5+r6 → r0=0, with no side effect.
- JZ with ra=0 and rb=0x80 → next fetch address 0x80; JZ with ra=1 → next fetch address pc+1. HALT → `halted`=1 and `mem_req` stays 0 indefinitely.
- With `CPU_CARRY_EN`: ADD 0xFFFFFFFF+1 → result 0, carry 1; then ADC 0+0 → result 1. Without the macro, opcode 11 leaves rd unchanged.
